// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline-entry layout and helpers for the forwarding/hazard scoreboard.
// Entry packs LSB-first as {store_reg, dest, flags}; stage 0 sits at the LSB end of the flattened array.
package cpu_pipe_pkg;

    localparam int FWD_SEL_RF = 0;

    typedef struct packed {
        logic memwrite;
        logic memread;
        logic regwrite;
        logic valid;
    } ent_flags_t;

    localparam int ENT_FLAG_W   = $bits(ent_flags_t);
    localparam int ENT_DEST_LSB = ENT_FLAG_W;

    function automatic int ent_w(input int reg_w);
        return ENT_FLAG_W + 2 * reg_w;
    endfunction

    function automatic int store_lsb(input int reg_w);
        return ENT_FLAG_W + reg_w;
    endfunction

    function automatic int sel_w(input int fwd_depth);
        return $clog2(fwd_depth + 1);
    endfunction

    // A hard-wired r0 must never look like a producer.
    function automatic logic can_write(input ent_flags_t f, input logic dest_zero,
                                       input logic zero_hard);
        return f.valid && f.regwrite && !(zero_hard && dest_zero);
    endfunction

endpackage

// File: rtl/fwd_match_lane.sv
// One operand's bypass select: youngest write-capable stage whose dest matches the EX source.
// Latency: combinational; backpressure: none (pure decode of registered state).
module fwd_match_lane
    import cpu_pipe_pkg::*;
#(
    parameter int REG_W     = 4,
    parameter int FWD_DEPTH = 2,
    parameter int ZERO_HARD = 1,
    localparam int ENT_W    = ent_w(REG_W),
    localparam int SEL_W    = sel_w(FWD_DEPTH)
) (
    input  logic [REG_W-1:0]               src_i,
    input  logic [(FWD_DEPTH+1)*ENT_W-1:0] stages_i,
    output logic [SEL_W-1:0]               sel_o
);

    ent_flags_t       flg  [FWD_DEPTH+1];
    logic [REG_W-1:0] dst  [FWD_DEPTH+1];
    logic             wcap [FWD_DEPTH+1];
    logic             unused_lane_bits;

    for (genvar g = 0; g <= FWD_DEPTH; g++) begin : g_unp
        assign flg[g]  = ent_flags_t'(stages_i[g*ENT_W +: ENT_FLAG_W]);
        assign dst[g]  = stages_i[g*ENT_W + ENT_DEST_LSB +: REG_W];
        assign wcap[g] = can_write(flg[g], dst[g] == '0, ZERO_HARD != 0);
    end

    assign unused_lane_bits = ^stages_i;

    // Scan oldest to youngest so the nearest producer overwrites older hits.
    always_comb begin
        sel_o = SEL_W'(FWD_SEL_RF);
        if (flg[0].valid) begin
            for (int i = FWD_DEPTH; i >= 1; i--) begin
                if (wcap[i] && dst[i] == src_i) begin
                    sel_o = SEL_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_scoreboard.sv
// Tracks in-flight destinations EX..last write stage; drives operand bypass, load-use stall, store-data forward.
// Latency: outputs combinational from registered stages; backpressure: stall holds ID and bubbles EX.
module fwd_hazard_scoreboard
    import cpu_pipe_pkg::*;
#(
    parameter int REG_W     = 4,
    parameter int NUM_SRC   = 2,
    parameter int FWD_DEPTH = 2,
    parameter int LOAD_LAT  = 1,
    parameter int ZERO_HARD = 1,
    parameter int CNT_W     = 16,
    localparam int SEL_W    = sel_w(FWD_DEPTH),
    localparam int ENT_W    = ent_w(REG_W)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     id_valid,
    input  logic [REG_W-1:0]         id_dest,
    input  logic                     id_regwrite,
    input  logic                     id_memread,
    input  logic                     id_memwrite,
    input  logic [NUM_SRC*REG_W-1:0] id_src,
    input  logic                     flush,
    output logic                     stall,
    output logic [NUM_SRC*SEL_W-1:0] fwd_sel,
    output logic                     fwd_store,
    output logic [CNT_W-1:0]         stall_cnt,
    output logic [CNT_W-1:0]         fwd_cnt
);

    localparam int STORE_SRC = (NUM_SRC > 1) ? 1 : 0;
    localparam int STO_LSB   = store_lsb(REG_W);

    logic [(FWD_DEPTH+1)*ENT_W-1:0] stages_q, stages_d;
    logic [NUM_SRC*REG_W-1:0]       ex_src_q, ex_src_d;
    logic [CNT_W-1:0]               stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]               fwd_cnt_q, fwd_cnt_d;
    logic [ENT_W-1:0]               new_ent;
    logic                           issue;
    logic                           load_hit;
    logic                           unused_stage_bits;

    ent_flags_t       flg  [FWD_DEPTH+1];
    logic [REG_W-1:0] dst  [FWD_DEPTH+1];
    logic [REG_W-1:0] sto  [FWD_DEPTH+1];
    logic             wcap [FWD_DEPTH+1];

    for (genvar g = 0; g <= FWD_DEPTH; g++) begin : g_unp
        assign flg[g]  = ent_flags_t'(stages_q[g*ENT_W +: ENT_FLAG_W]);
        assign dst[g]  = stages_q[g*ENT_W + ENT_DEST_LSB +: REG_W];
        assign sto[g]  = stages_q[g*ENT_W + STO_LSB +: REG_W];
        assign wcap[g] = can_write(flg[g], dst[g] == '0, ZERO_HARD != 0);
    end

    assign unused_stage_bits = ^stages_q;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_lane
        fwd_match_lane #(
            .REG_W     (REG_W),
            .FWD_DEPTH (FWD_DEPTH),
            .ZERO_HARD (ZERO_HARD)
        ) u_lane (
            .src_i    (ex_src_q[k*REG_W +: REG_W]),
            .stages_i (stages_q),
            .sel_o    (fwd_sel[k*SEL_W +: SEL_W])
        );
    end

    // A load still within LOAD_LAT of EX cannot supply its value to the issuing instruction.
    always_comb begin
        load_hit = 1'b0;
        for (int i = 0; i < LOAD_LAT; i++) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                if (wcap[i] && flg[i].memread && dst[i] == id_src[k*REG_W +: REG_W]) begin
                    load_hit = 1'b1;
                end
            end
        end
    end

    assign stall = id_valid && !flush && load_hit;
    assign issue = id_valid && !flush && !load_hit;

    if (FWD_DEPTH >= 2) begin : g_store_fwd
        assign fwd_store = flg[1].valid && flg[1].memwrite && wcap[2] && dst[2] == sto[1];
    end else begin : g_no_store_fwd
        assign fwd_store = 1'b0;
    end

    always_comb begin
        new_ent = '0;
        if (issue) begin
            new_ent = {id_src[STORE_SRC*REG_W +: REG_W], id_dest,
                       ent_flags_t'({id_memwrite, id_memread, id_regwrite, 1'b1})};
        end
        stages_d = {stages_q[FWD_DEPTH*ENT_W-1:0], new_ent};
        ex_src_d = issue ? id_src : ex_src_q;

        stall_cnt_d = stall_cnt_q;
        if (stall && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        fwd_cnt_d = fwd_cnt_q;
        if ((|fwd_sel || fwd_store) && fwd_cnt_q != '1) begin
            fwd_cnt_d = fwd_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stages_q    <= '0;
            ex_src_q    <= '0;
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            stages_q    <= stages_d;
            ex_src_q    <= ex_src_d;
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign fwd_cnt   = fwd_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Drives three scoreboard configurations with shared stimulus and checks each against a
// timestamped issue-history model: an instruction accepted in cycle t sits in stage (now-1-t).
module tb_fwd_hazard_scoreboard;

    localparam int NC = 3;

    logic       clk = 1'b0;
    logic       rst, id_valid, id_regwrite, id_memread, id_memwrite, flush;
    logic [3:0] id_dest;
    logic [7:0] id_src;

    logic        st_o  [NC];
    logic [3:0]  sel_o [NC];
    logic        fs_o  [NC];
    logic [15:0] sc_a, fc_a, sc_b, fc_b;
    logic [2:0]  sc_c, fc_c;

    always #5 clk = ~clk;

    fwd_hazard_scoreboard u_dut_a (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_dest(id_dest), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .id_memwrite(id_memwrite), .id_src(id_src), .flush(flush),
        .stall(st_o[0]), .fwd_sel(sel_o[0]), .fwd_store(fs_o[0]), .stall_cnt(sc_a), .fwd_cnt(fc_a));

    fwd_hazard_scoreboard #(.FWD_DEPTH(3), .LOAD_LAT(2)) u_dut_b (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_dest(id_dest), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .id_memwrite(id_memwrite), .id_src(id_src), .flush(flush),
        .stall(st_o[1]), .fwd_sel(sel_o[1]), .fwd_store(fs_o[1]), .stall_cnt(sc_b), .fwd_cnt(fc_b));

    fwd_hazard_scoreboard #(.ZERO_HARD(0), .CNT_W(3)) u_dut_c (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_dest(id_dest), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .id_memwrite(id_memwrite), .id_src(id_src), .flush(flush),
        .stall(st_o[2]), .fwd_sel(sel_o[2]), .fwd_store(fs_o[2]), .stall_cnt(sc_c), .fwd_cnt(fc_c));

    typedef struct {
        bit       ok;
        bit [3:0] dest;
        bit       rw, mr, mw;
        bit [3:0] s0, s1;
    } ins_t;

    int c_depth [NC] = '{2, 3, 2};
    int c_lat   [NC] = '{1, 2, 1};
    int c_zh    [NC] = '{1, 1, 0};
    int c_cmax  [NC] = '{65535, 65535, 7};

    ins_t hist [int];
    int   lo   [NC];
    int   scnt [NC];
    int   fcnt [NC];
    int   cyc;
    int   nvec = 0;
    int   nerr = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic ins_t at_stage(input int c, input int i);
        ins_t e;
        int   t;
        e.ok = 1'b0;
        t = cyc - 1 - i;
        if (t >= lo[c] && hist.exists(c * 1000000 + t)) e = hist[c * 1000000 + t];
        return e;
    endfunction

    function automatic bit producer(input int c, input ins_t e);
        return e.ok && e.rw && !(c_zh[c] != 0 && e.dest == 0);
    endfunction

    task automatic expect_cfg(input int c, output bit est, output logic [3:0] esel, output bit efs);
        ins_t e0, e1, e2, e;
        bit [3:0] src;
        int lane;
        esel = '0;
        e0 = at_stage(c, 0);
        for (int k = 0; k < 2; k++) begin
            src  = (k == 0) ? e0.s0 : e0.s1;
            lane = 0;
            if (e0.ok) begin
                for (int i = 1; i <= c_depth[c]; i++) begin
                    e = at_stage(c, i);
                    if (lane == 0 && producer(c, e) && e.dest == src) lane = i;
                end
            end
            esel[k*2 +: 2] = 2'(lane);
        end
        est = 1'b0;
        if (id_valid && !flush) begin
            for (int i = 0; i < c_lat[c]; i++) begin
                e = at_stage(c, i);
                if (producer(c, e) && e.mr && (e.dest == id_src[3:0] || e.dest == id_src[7:4]))
                    est = 1'b1;
            end
        end
        e1 = at_stage(c, 1);
        e2 = at_stage(c, 2);
        efs = (c_depth[c] >= 2) && e1.ok && e1.mw && producer(c, e2) && e2.dest == e1.s1;
    endtask

    task automatic step(input bit v, input int dst, input bit rw, input bit mr, input bit mw,
                        input int s0, input int s1, input bit fl, input bit r);
        bit         est   [NC];
        bit         efs   [NC];
        logic [3:0] esel  [NC];
        logic [31:0] gsc, gfc;
        ins_t       ni;
        rst = r; id_valid = v; id_dest = 4'(dst); id_regwrite = rw; id_memread = mr;
        id_memwrite = mw; id_src = {4'(s1), 4'(s0)}; flush = fl;
        #2;
        for (int c = 0; c < NC; c++) begin
            expect_cfg(c, est[c], esel[c], efs[c]);
            gsc = (c == 0) ? 32'(sc_a) : (c == 1) ? 32'(sc_b) : 32'(sc_c);
            gfc = (c == 0) ? 32'(fc_a) : (c == 1) ? 32'(fc_b) : 32'(fc_c);
            chk($sformatf("stall[%0d]", c), 32'(st_o[c]), 32'(est[c]));
            chk($sformatf("fwd_sel[%0d]", c), 32'(sel_o[c]), 32'(esel[c]));
            chk($sformatf("fwd_store[%0d]", c), 32'(fs_o[c]), 32'(efs[c]));
            chk($sformatf("stall_cnt[%0d]", c), gsc, 32'(scnt[c]));
            chk($sformatf("fwd_cnt[%0d]", c), gfc, 32'(fcnt[c]));
        end
        @(posedge clk);
        ni.ok = 1'b1; ni.dest = 4'(dst); ni.rw = rw; ni.mr = mr; ni.mw = mw;
        ni.s0 = 4'(s0); ni.s1 = 4'(s1);
        for (int c = 0; c < NC; c++) begin
            if (r) begin
                lo[c] = cyc + 1; scnt[c] = 0; fcnt[c] = 0;
            end else begin
                if (v && !fl && !est[c]) hist[c * 1000000 + cyc] = ni;
                if (est[c] && scnt[c] < c_cmax[c]) scnt[c]++;
                if ((esel[c] != 0 || efs[c]) && fcnt[c] < c_cmax[c]) fcnt[c]++;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic alu(input int d, input int a, input int b);
        step(1, d, 1, 0, 0, a, b, 0, 0);
    endtask
    task automatic ld(input int d, input int a);
        step(1, d, 1, 1, 0, a, 0, 0, 0);
    endtask
    task automatic st(input int data, input int base);
        step(1, 0, 0, 0, 1, base, data, 0, 0);
    endtask
    task automatic nop(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; id_valid = 1'b0; id_dest = '0; id_regwrite = 1'b0; id_memread = 1'b0;
        id_memwrite = 1'b0; id_src = '0; flush = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        cyc = 0;
        for (int c = 0; c < NC; c++) begin lo[c] = 0; scnt[c] = 0; fcnt[c] = 0; end

        // back-to-back RAW on both operands
        alu(3, 1, 2); alu(5, 3, 3); nop(3);
        // distance-2 producer, r0 operand (plus an r0 write for the soft-r0 config)
        alu(0, 1, 1); alu(4, 1, 2); alu(9, 1, 1); alu(6, 4, 0); nop(4);
        // load-use, use re-presented while stalled
        ld(7, 1); alu(8, 7, 2); alu(8, 7, 2); nop(4);
        ld(2, 1); alu(10, 2, 2); alu(10, 2, 2); alu(10, 2, 2); nop(5);
        // store data produced two ahead, then separated by a bubble
        alu(9, 1, 2); st(9, 1); nop(3);
        alu(9, 1, 2); nop(1); st(9, 1); nop(3);
        // flush wins over a load-use hazard
        ld(7, 1); step(1, 8, 1, 0, 0, 7, 2, 1, 0); nop(3);
        // reset in the middle of a long load-use stall
        ld(2, 1); alu(11, 2, 3); step(1, 11, 1, 0, 0, 2, 3, 0, 1); nop(3);

        for (int n = 0; n < 3000; n++) begin
            bit v, rw, mr, mw, fl, r;
            v  = ($urandom_range(0, 3) != 0);
            mr = ($urandom_range(0, 3) == 0);
            rw = mr || ($urandom_range(0, 9) < 6);
            mw = !mr && ($urandom_range(0, 6) == 0);
            fl = ($urandom_range(0, 15) == 0);
            r  = ($urandom_range(0, 199) == 0);
            step(v, $urandom_range(0, 7), rw, mr, mw, $urandom_range(0, 7), $urandom_range(0, 7), fl, r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
